// File: rtl/cfeb_demux_phase_scan.sv
// Scans all 32 demux phase settings ({posneg, delay_is}), records which ones deliver
// the expected pattern, then parks the demux in the middle of the longest passing window.
module cfeb_demux_phase_scan #(
  parameter int WIDTH    = 16,
  parameter int SETTLE   = 20,
  parameter int TEST_LEN = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dout1st,
  input  logic [WIDTH-1:0] dout2nd,
  input  logic [WIDTH-1:0] pat1st,
  input  logic [WIDTH-1:0] pat2nd,
  output logic             posneg,
  output logic [3:0]       delay_is,
  output logic             demux_clr,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [31:0]      pass_map,
  output logic [4:0]       best_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SETTLE, S_TEST, S_RECORD, S_SELECT, S_DONE
  } state_t;

  localparam logic [9:0] SETTLE_LAST = 10'(SETTLE - 1);
  localparam logic [9:0] TEST_LAST   = 10'(TEST_LEN - 1);

  state_t      state, state_nxt;
  logic [9:0]  cnt;
  logic [4:0]  idx;
  logic        err;
  logic [4:0]  restore;
  logic [4:0]  run_start, best_start;
  logic [5:0]  run_len, best_len;
  logic        busy_st;
  logic        mismatch;
  logic [4:0]  mid;

  // Centre of a run, biased toward the lower index for even lengths.
  function automatic logic [4:0] mid_index(input logic [4:0] s, input logic [5:0] len);
    return 5'({1'b0, s} + ((len - 6'd1) >> 1));
  endfunction

  assign busy_st   = (state != S_IDLE) && (state != S_DONE);
  assign busy      = busy_st;
  assign demux_clr = (state == S_CLEAR);
  assign mismatch  = (dout1st != pat1st) || (dout2nd != pat2nd);
  assign mid       = mid_index(best_start, best_len);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_CLEAR;
      S_CLEAR:        state_nxt = S_SETTLE;
      S_SETTLE:       if (cnt == SETTLE_LAST) state_nxt = S_TEST;
      S_TEST:         if (cnt == TEST_LAST) state_nxt = S_RECORD;
      S_RECORD:       state_nxt = (idx == 5'd31) ? S_SELECT : S_CLEAR;
      S_SELECT:       if (cnt[5]) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
    // abort outranks every other transition while a scan is running
    if (busy_st && abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      posneg     <= 1'b0;
      delay_is   <= 4'd0;
      done       <= 1'b0;
      found      <= 1'b0;
      pass_map   <= 32'd0;
      best_idx   <= 5'd0;
      restore    <= 5'd0;
      idx        <= 5'd0;
      cnt        <= 10'd0;
      err        <= 1'b0;
      run_start  <= 5'd0;
      run_len    <= 6'd0;
      best_start <= 5'd0;
      best_len   <= 6'd0;
    end else if (busy_st && abort) begin
      {posneg, delay_is} <= restore;
      done               <= 1'b0;
      found              <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            restore            <= {posneg, delay_is};
            {posneg, delay_is} <= 5'd0;
            idx                <= 5'd0;
            pass_map           <= 32'd0;
            done               <= 1'b0;
            found              <= 1'b0;
          end
        end
        S_CLEAR: cnt <= 10'd0;
        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt <= 10'd0;
            err <= 1'b0;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        S_TEST: begin
          cnt <= cnt + 10'd1;
          err <= err | mismatch;
        end
        S_RECORD: begin
          pass_map[idx] <= ~err;
          if (idx != 5'd31) begin
            idx                <= idx + 5'd1;
            {posneg, delay_is} <= idx + 5'd1;
          end else begin
            cnt        <= 10'd0;
            run_start  <= 5'd0;
            run_len    <= 6'd0;
            best_start <= 5'd0;
            best_len   <= 6'd0;
          end
        end
        S_SELECT: begin
          if (cnt[5]) begin
            found <= (best_len != 6'd0);
            done  <= 1'b1;
            if (best_len != 6'd0) begin
              best_idx           <= mid;
              {posneg, delay_is} <= mid;
            end else begin
              best_idx           <= 5'd0;
              {posneg, delay_is} <= restore;
            end
          end else begin
            cnt <= cnt + 10'd1;
            // strict '>' keeps the earliest run when lengths tie
            if (pass_map[cnt[4:0]]) begin
              run_len <= run_len + 6'd1;
              if (run_len == 6'd0) run_start <= cnt[4:0];
              if (run_len + 6'd1 > best_len) begin
                best_len   <= run_len + 6'd1;
                best_start <= (run_len == 6'd0) ? cnt[4:0] : run_start;
              end
            end else begin
              run_len <= 6'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cfeb_demux_phase_scan.sv
// Bench for cfeb_demux_phase_scan: a behavioural demux answers each phase setting,
// expected scan results are queued at launch and compared when done rises.
module tb_cfeb_demux_phase_scan;
  localparam int W  = 16;
  localparam int ST = 2;
  localparam int TL = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  dout1st, dout2nd, pat1st, pat2nd;
  logic          posneg;
  logic [3:0]    delay_is;
  logic          demux_clr, busy, done, found;
  logic [31:0]   pass_map;
  logic [4:0]    best_idx;

  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            phase = 0;
  int            t0 = 0;
  int            mode = 0;
  logic [31:0]   good = 32'd0;
  logic          bad;
  logic [42:0]   sb_q[$];
  logic [42:0]   exp_v;
  logic [42:0]   obs_v;

  cfeb_demux_phase_scan #(.WIDTH(W), .SETTLE(ST), .TEST_LEN(TL)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .dout1st(dout1st), .dout2nd(dout2nd), .pat1st(pat1st), .pat2nd(pat2nd),
    .posneg(posneg), .delay_is(delay_is), .demux_clr(demux_clr), .busy(busy),
    .done(done), .found(found), .pass_map(pass_map), .best_idx(best_idx)
  );

  always #5 clock = ~clock;

  // phase = cycles since the demux clear: 1..ST settle, ST+1..ST+TL test
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (demux_clr)       phase <= 1;
    else if (phase != 0) phase <= phase + 1;
  end

  // Demux model. Modes: 0 mask of good settings, 1 error in last test cycle only,
  // 2 error in first test cycle only, 3 error only while settling.
  always_comb begin
    bad = 1'b0;
    case (mode)
      0: bad = !good[{posneg, delay_is}];
      1: bad = (phase == ST + TL);
      2: bad = (phase == ST + 1);
      3: bad = (phase >= 1) && (phase <= ST);
      default: bad = 1'b0;
    endcase
    dout1st = pat1st ^ ((mode != 1 && bad) ? 16'h0001 : 16'h0000);
    dout2nd = pat2nd ^ ((mode == 1 && bad) ? 16'h8000 : 16'h0000);
  end

  function automatic logic [42:0] pack_exp(input logic [31:0] pm, input logic f,
                                           input logic [4:0] bi, input logic pn,
                                           input logic [3:0] d);
    return {pm, f, bi, pn, d};
  endfunction

  task automatic launch(input logic [42:0] e);
    sb_q.push_back(e);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(output int lat);
    int n;
    n = 0;
    while (!done && n < 400) begin
      @(negedge clock);
      n++;
    end
    lat = cyc - t0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", done, n);
    end
  endtask

  task automatic run_mask(input string name, input int m, input logic [31:0] g,
                          input logic [42:0] e);
    int lat;
    mode = m; good = g;
    launch(e);
    wait_done(lat);
    exp_v = sb_q.pop_front();
    obs_v = {pass_map, found, best_idx, posneg, delay_is};
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL %s: {pass_map,found,best_idx,posneg,delay_is} got %h required %h",
               name, obs_v, exp_v);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({posneg, delay_is, demux_clr, busy, done, found, pass_map, best_idx} !== 45'd0) begin
      errors++;
      $display("FAIL reset_state: got %h required 0",
               {posneg, delay_is, demux_clr, busy, done, found, pass_map, best_idx});
    end
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_all_pass();
    int lat;
    mode = 0; good = 32'hFFFF_FFFF;
    launch(pack_exp(32'hFFFF_FFFF, 1'b1, 5'd15, 1'b0, 4'd15));
    checks++;
    if ({busy, demux_clr} !== 2'b11) begin
      errors++;
      $display("FAIL clear_entry: {busy,demux_clr} got %b required 11", {busy, demux_clr});
    end
    @(negedge clock);
    checks++;
    if ({busy, demux_clr} !== 2'b10) begin
      errors++;
      $display("FAIL clear_width: {busy,demux_clr} got %b required 10", {busy, demux_clr});
    end
    wait_done(lat);
    checks++;
    if (lat !== 32 * (2 + ST + TL) + 33) begin
      errors++;
      $display("FAIL done_latency: got %0d required %0d", lat, 32 * (2 + ST + TL) + 33);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_at_done: got %b required 0", busy);
    end
    exp_v = sb_q.pop_front();
    obs_v = {pass_map, found, best_idx, posneg, delay_is};
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL all_pass: got %h required %h", obs_v, exp_v);
    end
  endtask

  task automatic test_windows();
    run_mask("upper_half", 0, 32'hFFFF_0000, pack_exp(32'hFFFF_0000, 1'b1, 5'd23, 1'b1, 4'd7));
    run_mask("two_runs",   0, 32'h0000_7C1C, pack_exp(32'h0000_7C1C, 1'b1, 5'd12, 1'b0, 4'd12));
    run_mask("tie_low",    0, 32'h0070_0038, pack_exp(32'h0070_0038, 1'b1, 5'd4,  1'b0, 4'd4));
    run_mask("no_wrap",    0, 32'hC000_0403, pack_exp(32'hC000_0403, 1'b1, 5'd0,  1'b0, 4'd0));
  endtask

  task automatic test_fail_restore();
    run_mask("preset_25",    0, 32'h0200_0000, pack_exp(32'h0200_0000, 1'b1, 5'd25, 1'b1, 4'd9));
    run_mask("last_cycle",   1, 32'd0, pack_exp(32'd0, 1'b0, 5'd0, 1'b1, 4'd9));
    run_mask("first_cycle",  2, 32'd0, pack_exp(32'd0, 1'b0, 5'd0, 1'b1, 4'd9));
    run_mask("settle_ignored", 3, 32'd0, pack_exp(32'hFFFF_FFFF, 1'b1, 5'd15, 1'b0, 4'd15));
  endtask

  task automatic test_abort();
    int n;
    int lat;
    // abort while DONE is ignored
    @(negedge clock); abort = 1'b1;
    @(negedge clock); abort = 1'b0;
    checks++;
    if ({done, busy, pass_map, found, best_idx, posneg, delay_is} !==
        {1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 5'd15, 1'b0, 4'd15}) begin
      errors++;
      $display("FAIL abort_in_done: got %h", {done, busy, pass_map, found, best_idx, posneg, delay_is});
    end
    mode = 0; good = 32'hFFFF_FFFF;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    t0 = cyc;
    n = 0;
    while (!({posneg, delay_is} == 5'd5 && phase == ST + 1) && n < 200) begin
      @(negedge clock);
      n++;
      start = (n == 20);
    end
    start = 1'b0;
    lat = cyc - t0;
    checks++;
    if (lat !== 5 * (2 + ST + TL) + ST + 1) begin
      errors++;
      $display("FAIL start_while_busy: reached idx5 test after %0d required %0d",
               lat, 5 * (2 + ST + TL) + ST + 1);
    end
    abort = 1'b1;
    @(negedge clock); abort = 1'b0;
    checks++;
    if ({busy, done, found, demux_clr, pass_map, posneg, delay_is} !==
        {4'b0000, 32'h0000_001F, 1'b0, 4'd15}) begin
      errors++;
      $display("FAIL abort_test5: got %h required %h",
               {busy, done, found, demux_clr, pass_map, posneg, delay_is},
               {4'b0000, 32'h0000_001F, 1'b0, 4'd15});
    end
    // abort while IDLE is ignored
    abort = 1'b1;
    @(negedge clock); abort = 1'b0;
    @(negedge clock);
    checks++;
    if ({busy, done, pass_map, posneg, delay_is} !== {2'b00, 32'h0000_001F, 1'b0, 4'd15}) begin
      errors++;
      $display("FAIL abort_in_idle: got %h", {busy, done, pass_map, posneg, delay_is});
    end
    // start and abort together from IDLE: start wins
    sb_q.push_back(pack_exp(32'hFFFF_FFFF, 1'b1, 5'd15, 1'b0, 4'd15));
    start = 1'b1; abort = 1'b1;
    @(negedge clock); start = 1'b0; abort = 1'b0;
    t0 = cyc;
    checks++;
    if ({busy, demux_clr} !== 2'b11) begin
      errors++;
      $display("FAIL start_abort_same: {busy,demux_clr} got %b required 11", {busy, demux_clr});
    end
    wait_done(lat);
    exp_v = sb_q.pop_front();
    obs_v = {pass_map, found, best_idx, posneg, delay_is};
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL after_start_abort: got %h required %h", obs_v, exp_v);
    end
  endtask

  task automatic test_reset_midscan();
    int n;
    int lat;
    mode = 0; good = 32'hFFFF_FFFF;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    n = 0;
    while (!({posneg, delay_is} == 5'd3 && phase == 1) && n < 200) begin
      @(negedge clock);
      n++;
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({posneg, delay_is, demux_clr, busy, done, found, pass_map, best_idx} !== 45'd0) begin
      errors++;
      $display("FAIL async_reset: got %h required 0",
               {posneg, delay_is, demux_clr, busy, done, found, pass_map, best_idx});
    end
    @(negedge clock); reset_n = 1'b1;
    mode = 0; good = 32'h0000_7C1C;
    launch(pack_exp(32'h0000_7C1C, 1'b1, 5'd12, 1'b0, 4'd12));
    wait_done(lat);
    checks++;
    if (lat !== 32 * (2 + ST + TL) + 33) begin
      errors++;
      $display("FAIL post_reset_latency: got %0d required %0d", lat, 32 * (2 + ST + TL) + 33);
    end
    exp_v = sb_q.pop_front();
    obs_v = {pass_map, found, best_idx, posneg, delay_is};
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL post_reset_scan: got %h required %h", obs_v, exp_v);
    end
  endtask

  initial begin
    pat1st = 16'($urandom);
    pat2nd = 16'($urandom);
    test_reset();
    test_all_pass();
    test_windows();
    test_fail_restore();
    test_abort();
    test_reset_midscan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cfeb_demux_phase_scan.md
CFEB_DEMUX_PHASE_SCAN -- requirements
Module: cfeb_demux_phase_scan

Interface
REQ-001 Parameter WIDTH, default 16, width of the demux data and expected-pattern buses.
REQ-002 Parameter SETTLE, default 20, number of cycles to wait after each setting change before checking data (range 1..255).
REQ-003 Parameter TEST_LEN, default 64, number of consecutive compare cycles per setting (range 1..1023).
REQ-004 Port clock  in  1  40MHz TMB main clock; single clock domain; all logic on rising edge.
REQ-005 Port reset_n  in  1  asynchronous, active-low reset.
REQ-006 Port start  in  1  single-cycle request to begin a scan.
REQ-007 Port abort  in  1  terminates a running scan.
REQ-008 Port dout1st  in  WIDTH  demux 1st-in-time data.
REQ-009 Port dout2nd  in  WIDTH  demux 2nd-in-time data.
REQ-010 Port pat1st  in  WIDTH  expected 1st-in-time pattern.
REQ-011 Port pat2nd  in  WIDTH  expected 2nd-in-time pattern.
REQ-012 Port posneg  out  1  inter-stage clock select driven to the demux.
REQ-013 Port delay_is  out  4  inter-stage delay driven to the demux.
REQ-014 Port demux_clr  out  1  synchronous clear driven to the demux.
REQ-015 Port busy  out  1  high from the cycle after an accepted start until DONE or IDLE.
REQ-016 Port done  out  1  level; high after scan completion until the next accepted start.
REQ-017 Port found  out  1  valid while done=1; indicates that at least one setting passed.
REQ-018 Port pass_map  out  32  per-setting pass bit; setting index idx = {posneg, delay_is}.
REQ-019 Port best_idx  out  5  selected setting index; valid while done=1.

Function
REQ-020 States: IDLE, CLEAR, SETTLE, TEST, RECORD, SELECT, DONE.
REQ-021 IDLE/DONE + start=1 -> CLEAR, with the following actions:
  - set idx=0;
  - drive posneg=0, delay_is=0;
  - clear pass_map, done, and found;
  - save the current posneg/delay_is as the restore value.
REQ-022 A start received in any other state is ignored.
REQ-023 CLEAR: demux_clr=1 for exactly 1 cycle -> SETTLE; demux_clr=0 in all other states.
REQ-024 SETTLE: lasts SETTLE cycles -> TEST; the data inputs are ignored.
REQ-025 TEST: lasts TEST_LEN cycles.
  - A setting fails if dout1st!=pat1st or dout2nd!=pat2nd in any TEST cycle (sticky error flag).
  - The error flag is cleared on entry to TEST.
REQ-026 RECORD: 1 cycle.
  - Write pass_map[idx] = ~error.
  - If idx<31: increment idx, drive {posneg,delay_is}=idx+1, go to CLEAR.
  - If idx=31: go to SELECT.
REQ-027 Time per setting: exactly 1+SETTLE+TEST_LEN+1 cycles; posneg/delay_is change only on RECORD exit.
REQ-028 SELECT: walks pass_map bits 0..31 one bit per cycle (32 cycles), then 1 finalize cycle -> DONE.
  - Finds the longest run of consecutive 1s in index order.
  - Runs do not wrap from 31 to 0.
  - On equal-length runs, the lowest start index wins.
REQ-029 best_idx = run_start + floor((run_len-1)/2).
  - run length is 6 bits, so a full run of 32 does not overflow.
REQ-030 found = (run_len != 0).
  - If found=1: drive {posneg,delay_is}=best_idx.
  - If found=0: drive best_idx=0 and restore the saved posneg/delay_is.
REQ-031 DONE: done=1, busy=0; hold all outputs until the next accepted start.
REQ-032 abort=1 in any busy state -> IDLE on the next edge.
  - demux_clr=0; restore the saved posneg/delay_is.
  - done=0, found=0.
  - pass_map keeps its partially written contents.
  - abort takes priority over all other transitions.
REQ-033 abort in IDLE or DONE has no effect.
REQ-034 start and abort asserted in the same cycle while IDLE -> the start is accepted; abort is ignored.

Reset
REQ-035 reset_n=0 asynchronously forces the following values, independent of clock:
  - state=IDLE;
  - posneg=0, delay_is=0, demux_clr=0;
  - busy=0, done=0, found=0;
  - pass_map=0, best_idx=0;
  - restore value=0.
REQ-036 Reset asserted mid-scan discards all progress; the first start after reset_n rises begins a fresh scan at idx 0.

Verification
REQ-037 All data matches, SETTLE=2, TEST_LEN=4 -> pass_map=FFFFFFFF, found=1, best_idx=15 (posneg=0, delay_is=15); done rises 32*8+33 cycles after the CLEAR entry.
REQ-038 Mismatch only while posneg=0 -> pass_map=FFFF0000, best_idx=23 (posneg=1, delay_is=7).
REQ-039 Passes at idx 2..4 and idx 10..14 -> pass_map=00007C1C, best_idx=12 (posneg=0, delay_is=12).
REQ-040 Single-bit mismatch injected in the last TEST cycle of every setting, with posneg/delay_is preset to 1/9 -> pass_map=0, found=0, best_idx=0, outputs restored to posneg=1, delay_is=9.
REQ-041 abort during TEST of idx 5 -> IDLE next cycle, busy=0, done=0, pass_map bits 0..4 retained, posneg/delay_is restored; a start during busy is ignored (idx is not reset).
REQ-042 reset_n pulsed low during SETTLE -> all outputs at their reset values immediately, without a clock edge; a subsequent start performs a complete scan.
